// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with KMP-style overlap handling.
// Optional saturating match counter is enabled by defining SEQ_DET_CNT_EN.
module seq_detector_param #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b100,
  parameter int                 STATE_W = 3,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               clear,
  output logic               out,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int NUM_ST = 2 ** STATE_W;

  if (PAT_LEN < 1 || PAT_LEN > 16) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN must be in 1..16");
  end
  if (NUM_ST <= PAT_LEN) begin : g_bad_state_w
    $error("seq_detector_param: 2**STATE_W must exceed PAT_LEN");
  end

  // j-th pattern bit in arrival order (j=0 is the MSB, received first)
  function automatic logic pat_bit(int j);
    logic [PAT_LEN-1:0] sh;
    if (j < 0 || j >= PAT_LEN) return 1'b0;
    sh = PATTERN >> (PAT_LEN - 1 - j);
    return sh[0];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix of length k) followed by b
  function automatic int kmp_next(int k, logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    for (int len = 1; len <= k + 1; len++) begin
      if (len <= PAT_LEN) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++) begin
          idx = k + 1 - len + j;
          sb  = (idx < k) ? pat_bit(idx) : b;
          if (sb != pat_bit(j)) ok = 1'b0;
        end
        if (ok) best = len;
      end
    end
    return best;
  endfunction

  function automatic int kmp_border();
    int   best;
    logic ok;
    best = 0;
    for (int len = 1; len < PAT_LEN; len++) begin
      ok = 1'b1;
      for (int j = 0; j < len; j++) begin
        if (pat_bit(PAT_LEN - len + j) != pat_bit(j)) ok = 1'b0;
      end
      if (ok) best = len;
    end
    return best;
  endfunction

  localparam logic [STATE_W-1:0] FULL_ST   = STATE_W'(PAT_LEN);
  localparam logic [STATE_W-1:0] BORDER_ST = STATE_W'(kmp_border());

  logic [STATE_W-1:0] nxt0_tab [NUM_ST];
  logic [STATE_W-1:0] nxt1_tab [NUM_ST];

  // Entries at or above PAT_LEN are never used as effective states; keep them 0
  for (genvar gi = 0; gi < NUM_ST; gi++) begin : g_tab
    localparam int N0 = (gi < PAT_LEN) ? kmp_next(gi, 1'b0) : 0;
    localparam int N1 = (gi < PAT_LEN) ? kmp_next(gi, 1'b1) : 0;
    assign nxt0_tab[gi] = STATE_W'(N0);
    assign nxt1_tab[gi] = STATE_W'(N1);
  end

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] eff_st;
  logic [STATE_W-1:0] state_d;
  logic               out_q;
  logic               hit;

  always_comb begin
    eff_st = state_q;
    if (state_q == FULL_ST) eff_st = overlap ? BORDER_ST : '0;
    state_d = in ? nxt1_tab[eff_st] : nxt0_tab[eff_st];
  end

  assign hit = in_valid && (state_d == FULL_ST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      out_q   <= 1'b0;
    end else if (clear) begin
      state_q <= '0;
      out_q   <= 1'b0;
    end else if (in_valid) begin
      state_q <= state_d;
      out_q   <= hit;
    end else begin
      out_q   <= 1'b0;
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

  assign out   = out_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: two instances (3'b100 and 4'b1010 with a
// 2-bit counter) share one stimulus stream and are checked against a history-based model.
module tb_seq_detector_param;

  localparam int A_LEN  = 3;
  localparam int A_PAT  = 4;    // 3'b100
  localparam int A_CMAX = 255;
  localparam int B_LEN  = 4;
  localparam int B_PAT  = 10;   // 4'b1010
  localparam int B_CMAX = 3;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_b = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       clear = 1'b0;
  logic       out_a, out_b;
  logic [2:0] state_a, state_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  seq_detector_param u_dut_a (
    .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid), .overlap(overlap),
    .clear(clear), .out(out_a), .state(state_a), .match_cnt(cnt_a)
  );

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .STATE_W(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid), .overlap(overlap),
    .clear(clear), .out(out_b), .state(state_b), .match_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {int hist; int hlen; int st; int cnt;} model_t;
  typedef struct {bit out; int st; int cnt;} exp_t;

  model_t ma, mb;
  exp_t   qa[$];
  exp_t   qb[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic model_t zero_model();
    model_t m;
    m.hist = 0; m.hlen = 0; m.st = 0; m.cnt = 0;
    return m;
  endfunction

  // State = longest pattern prefix that ends the remembered history; a completed match
  // sampled with overlap=0 forgets the history before the new bit.
  function automatic model_t step(model_t m, int pat, int len, int cmax, bit ov, bit b);
    model_t r;
    r = m;
    if (r.st == len && !ov) begin
      r.hist = 0;
      r.hlen = 0;
    end
    r.hist = ((r.hist << 1) | int'(b)) & ((1 << len) - 1);
    if (r.hlen < len) r.hlen++;
    r.st = 0;
    for (int l = 1; l <= r.hlen; l++) begin
      if ((r.hist & ((1 << l) - 1)) == ((pat >> (len - l)) & ((1 << l) - 1))) r.st = l;
    end
    if (r.st == len && r.cnt < cmax) r.cnt++;
    return r;
  endfunction

  function automatic exp_t expect_of(model_t m, bit o);
    exp_t e;
    e.out = o;
    e.st  = m.st;
    e.cnt = CNT_EN ? m.cnt : 0;
    return e;
  endfunction

  // Called at a negedge; drives one input cycle, queues expectations, returns at next negedge
  task automatic cycle(bit b, bit v, bit ov, bit clr);
    bit oa, ob;
    in_b = b; in_valid = v; overlap = ov; clear = clr;
    oa = 1'b0; ob = 1'b0;
    if (clr) begin
      ma = zero_model();
      mb = zero_model();
    end else if (v) begin
      ma = step(ma, A_PAT, A_LEN, A_CMAX, ov, b);
      mb = step(mb, B_PAT, B_LEN, B_CMAX, ov, b);
      oa = (ma.st == A_LEN);
      ob = (mb.st == B_LEN);
    end
    qa.push_back(expect_of(ma, oa));
    qb.push_back(expect_of(mb, ob));
    @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_a_state"}, int'(state_a), 0);
    chk({tag, "_a_out"},   int'(out_a),   0);
    chk({tag, "_a_cnt"},   int'(cnt_a),   0);
    chk({tag, "_b_state"}, int'(state_b), 0);
    chk({tag, "_b_out"},   int'(out_b),   0);
    chk({tag, "_b_cnt"},   int'(cnt_b),   0);
  endtask

  // Called at a negedge; asserts reset between edges and checks it acts immediately
  task automatic async_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    #2;
    chk("pre_rst_a_state", int'(state_a), ma.st);
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    ma = zero_model();
    mb = zero_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_out",   int'(out_a),   int'(e.out));
        chk("a_state", int'(state_a), e.st);
        chk("a_cnt",   int'(cnt_a),   e.cnt);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_out",   int'(out_b),   int'(e.out));
        chk("b_state", int'(state_b), e.st);
        chk("b_cnt",   int'(cnt_b),   e.cnt);
      end
    end
  end

  initial begin : driver
    bit s1 [6];
    bit s2 [6];
    bit ov;
    s1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    s2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ma = zero_model();
    mb = zero_model();
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // 1,0,0,1,0,0 with overlap
    foreach (s1[i]) cycle(s1[i], 1'b1, 1'b1, 1'b0);
    // 1,0,1,0,1,0 with overlap, then without
    async_reset();
    foreach (s2[i]) cycle(s2[i], 1'b1, 1'b1, 1'b0);
    async_reset();
    foreach (s2[i]) cycle(s2[i], 1'b1, 1'b0, 1'b0);
    // 1,0,0 with three invalid cycles between valid bits
    async_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(s1[i], 1'b1, 1'b1, 1'b0);
      if (i < 2) repeat (3) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    end
    // clear together with the completing bit
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    foreach (s1[i]) cycle(s1[i], 1'b1, 1'b1, 1'b0);
    // mid-pattern async reset, then normal detection
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 3; i++) cycle(s1[i], 1'b1, 1'b1, 1'b0);

    // randomized stream: counters saturate, overlap toggles, occasional clear
    ov = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) ov = ~ov;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), ov,
            ($urandom_range(0, 99) < 2));
    end

    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drain", qa.size() + qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
